turn_ctrl: RTL

//  Game sequencer and write arbiter for the 4x4 board register array. Accepts move

---
 rtl/turn_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/turn_ctrl.sv
// Turn sequencer and single-writer arbiter for the 4x4 board array.
// Serialises player moves (check empty, write, report) and times display saves around writes.
module turn_ctrl #(
  parameter logic        FIRST   = 1'b0,
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned TO_W    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [3:0] addr0,
  input  logic [3:0] addr1,
  output logic [1:0] gnt,
  output logic [1:0] rej,
  output logic       wen,
  output logic [3:0] waddr,
  output logic [1:0] I,
  input  logic [1:0] wY,
  input  logic [9:0] gameover,
  input  logic       frame_end,
  output logic       save,
  output logic       turn,
  output logic       over,
  output logic       timeout,
  output logic [2:0] dbg_state
);

  // Handshake: req[p] is a level sampled only in IDLE/OVER; gnt/rej/timeout/save
  // are single-cycle pulses, wen is high for exactly the one write cycle.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_WRITE = 3'd2,
    S_POST  = 3'd3,
    S_OVER  = 3'd4,
    S_CLEAR = 3'd5
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  state_t          r_state;
  logic            r_turn;
  logic            r_starter;
  logic [3:0]      r_waddr;
  logic [1:0]      r_i;
  logic            r_wen;
  logic [1:0]      r_gnt;
  logic [1:0]      r_rej;
  logic            r_save;
  logic            r_save_pend;
  logic            r_timeout;
  logic            r_over;
  logic [TO_W-1:0] r_cnt;

  logic w_req_turn;
  logic w_req_other;
  logic w_stay;
  logic w_enter;

  // The player code written to the array doubles as the one-hot pulse mask.
  function automatic logic [1:0] f_onehot(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  assign w_req_turn  = req[r_turn];
  assign w_req_other = req[~r_turn];

  // Board is stable only in IDLE/OVER: w_stay = remain there this cycle,
  // w_enter = arrive there next cycle from a move or clear sequence.
  assign w_stay  = ((r_state == S_IDLE) && !w_req_turn) ||
                   ((r_state == S_OVER) && (req == 2'b00));
  assign w_enter = ((r_state == S_CHECK) && (wY != 2'b00)) ||
                   (r_state == S_POST) || (r_state == S_CLEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_turn      <= FIRST;
      r_starter   <= FIRST;
      r_waddr     <= 4'd0;
      r_i         <= 2'b00;
      r_wen       <= 1'b0;
      r_gnt       <= 2'b00;
      r_rej       <= 2'b00;
      r_save      <= 1'b0;
      r_save_pend <= 1'b0;
      r_timeout   <= 1'b0;
      r_over      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_gnt     <= 2'b00;
      r_rej     <= 2'b00;
      r_wen     <= 1'b0;
      r_timeout <= 1'b0;
      // Frame ends seen mid-move collapse into one save on return to a stable state.
      r_save      <= (w_stay && frame_end) || (w_enter && (r_save_pend || frame_end));
      r_save_pend <= !w_enter && (r_save_pend || (frame_end && !w_stay));
      case (r_state)
        S_IDLE: begin
          if (w_req_other) r_rej <= f_onehot(~r_turn);
          if (w_req_turn) begin
            r_waddr <= r_turn ? addr1 : addr0;
            r_i     <= f_onehot(r_turn);
            r_cnt   <= '0;
            r_state <= S_CHECK;
          end else if (TIMEOUT > 0) begin
            if (r_cnt == TO_LAST) begin
              r_timeout <= 1'b1;
              r_turn    <= ~r_turn;
              r_cnt     <= '0;
            end else begin
              r_cnt <= r_cnt + TO_W'(1);
            end
          end
        end
        S_CHECK: begin
          if (wY != 2'b00) begin
            r_rej   <= f_onehot(r_turn);
            r_state <= S_IDLE;
          end else begin
            r_wen   <= 1'b1;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_gnt   <= f_onehot(r_turn);
          r_state <= S_POST;
        end
        S_POST: begin
          if (|gameover) begin
            r_over  <= 1'b1;
            r_state <= S_OVER;
          end else begin
            r_turn  <= ~r_turn;
            r_state <= S_IDLE;
          end
        end
        S_OVER: begin
          if (|req) begin
            r_over  <= 1'b0;
            r_wen   <= 1'b1;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_starter <= ~r_starter;
          r_turn    <= ~r_starter;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign rej       = r_rej;
  assign wen       = r_wen;
  assign waddr     = r_waddr;
  assign I         = r_i;
  assign save      = r_save;
  assign turn      = r_turn;
  assign over      = r_over;
  assign timeout   = r_timeout;
  assign dbg_state = r_state;

endmodule
